con_run_ctl: RTL and testbench

- Parametrised successor to the EBOX run/start/ucode-state logic in CON.
- Per-channel RUN latch and START pulse generation, each passed through a configurable synchroniser depth.
- Decodes diagnostic control functions, holds an NSTATE-wide microcode state register, and drives an 8-bit diagnostic readback byte.
- Sits between CTL diag decode / CRAM MAGIC and MCL/PI consumers of RUN/START.

---
 rtl/con_run_ctl.sv | 147 ++++++++++++++
 tb/tb_con_run_ctl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/con_run_ctl.sv
// con_run_ctl: per-channel RUN/START synchronisers, diag function decode,
// microcode state flags and diag readback. Define CON_RUN_STEP_EN for single-step.
module con_run_ctl #(
  parameter int NCH        = 2,
  parameter int SYNC_DEPTH = 3,
  parameter int NSTATE     = 4
) (
  input  logic                clk,
  input  logic                MR_RESET,
  input  logic                DIAG_CTL_FUNC_01x,
  input  logic [2:0]          DIAG_DS,
  input  logic [2:0]          DIAG_CH,
  input  logic [NCH-1:0]      HALT,
  input  logic                COND_EBOX_STATE,
  input  logic [2*NSTATE-1:0] MAGIC,
  input  logic                DIAG_READ,
  input  logic [2:0]          DIAG_SEL,
  output logic [NCH-1:0]      RUN,
  output logic [NCH-1:0]      START,
  output logic                IR_STROBE,
  output logic                DRAM_STROBE,
  output logic [NSTATE-1:0]   UCODE_STATE,
  output logic [7:0]          DIAG_DATA
);

  typedef enum logic [2:0] {
    DS_CLR_RUN    = 3'b000,
    DS_SET_RUN    = 3'b001,
    DS_CONTINUE   = 3'b010,
    DS_STEP       = 3'b011,
    DS_IR_STROBE  = 3'b100,
    DS_DRAM_STROBE= 3'b101,
    DS_NOP_6      = 3'b110,
    DS_NOP_7      = 3'b111
  } diag_ds_e;

  diag_ds_e ds;
  logic [NCH-1:0] ch_hit, clr, set_run, cont, step, fire, done;
  logic [NCH-1:0] run_l, pend, step_l;
  logic [NCH-1:0] run_nxt, pend_nxt;
  logic [NCH-1:0][SYNC_DEPTH-1:0] rsync, psync;
  logic [SYNC_DEPTH:0] tap;
  logic [NSTATE-1:0] ucode_nxt;
  logic [7:0] rd;

  always_comb begin
    ds       = diag_ds_e'(DIAG_DS);
    ch_hit   = '0;
    clr      = '0;
    set_run  = '0;
    cont     = '0;
    step     = '0;
    fire     = '0;
    done     = '0;
    run_nxt  = '0;
    pend_nxt = '0;
    RUN      = '0;
    tap      = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      // Channel numbers >= NCH never match, so out-of-range selects are no-ops.
      ch_hit[i]  = DIAG_CTL_FUNC_01x && (DIAG_CH == 3'(i));
      clr[i]     = (ch_hit[i] && ds == DS_CLR_RUN) || HALT[i];
      set_run[i] = ch_hit[i] && ds == DS_SET_RUN;
      cont[i]    = ch_hit[i] && ds == DS_CONTINUE;
`ifdef CON_RUN_STEP_EN
      step[i]    = ch_hit[i] && ds == DS_STEP;
`endif
      // Fire one edge ahead of the chain output rising, so START is registered
      // and pend/step can clear on the same edge START asserts.
      tap        = {psync[i], pend[i]};
      fire[i]    = tap[SYNC_DEPTH-1] && !tap[SYNC_DEPTH];
      done[i]    = fire[i] && step_l[i];
      RUN[i]     = rsync[i][SYNC_DEPTH-1];
      if (clr[i])                     run_nxt[i] = 1'b0;
      else if (set_run[i] || step[i]) run_nxt[i] = 1'b1;
      else if (done[i])               run_nxt[i] = 1'b0;
      else                            run_nxt[i] = run_l[i];
      pend_nxt[i] = cont[i] || step[i] || (pend[i] && !fire[i]);
    end
  end

  always_comb begin
    ucode_nxt = '0;
    for (int unsigned i = 0; i < NSTATE; i++) begin
      ucode_nxt[i] = (MAGIC[2*i+1] | MAGIC[2*i]) & (UCODE_STATE[i] | MAGIC[2*i+1]);
    end
  end

  always_ff @(posedge clk) begin
    if (MR_RESET) begin
      run_l       <= '0;
      pend        <= '0;
      rsync       <= '0;
      psync       <= '0;
      START       <= '0;
      IR_STROBE   <= 1'b0;
      DRAM_STROBE <= 1'b0;
      UCODE_STATE <= '0;
    end else begin
      run_l       <= run_nxt;
      pend        <= pend_nxt;
      START       <= fire;
      for (int unsigned i = 0; i < NCH; i++) begin
        rsync[i] <= SYNC_DEPTH'({rsync[i], run_l[i]});
        // Gap the chain input on fire so a same-edge re-arm still makes a new edge.
        psync[i] <= SYNC_DEPTH'({psync[i], pend[i] & ~fire[i]});
      end
      IR_STROBE   <= DIAG_CTL_FUNC_01x && ds == DS_IR_STROBE;
      DRAM_STROBE <= DIAG_CTL_FUNC_01x && ds == DS_DRAM_STROBE;
      if (COND_EBOX_STATE) UCODE_STATE <= ucode_nxt;
    end
  end

`ifdef CON_RUN_STEP_EN
  logic [NCH-1:0] step_nxt;

  always_comb begin
    step_nxt = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (clr[i])       step_nxt[i] = 1'b0;
      else if (step[i]) step_nxt[i] = 1'b1;
      else if (done[i]) step_nxt[i] = 1'b0;
      else              step_nxt[i] = step_l[i];
    end
  end

  always_ff @(posedge clk) begin
    if (MR_RESET) step_l <= '0;
    else          step_l <= step_nxt;
  end
`else
  assign step_l = '0;
`endif

  always_comb begin
    case (DIAG_SEL)
      3'd0:    rd = 8'(RUN);
      3'd1:    rd = 8'(pend);
      3'd2:    rd = 8'(run_l);
      3'd3:    rd = 8'(UCODE_STATE);
      3'd4:    rd = 8'({step_l, HALT});
      default: rd = '0;
    endcase
    DIAG_DATA = DIAG_READ ? rd : '0;
  end

endmodule

// File: tb/tb_con_run_ctl.sv
// Randomised and directed bench for con_run_ctl against an event-level model.
module tb_con_run_ctl;
  localparam int NCH = 2;
  localparam int D   = 3;
  localparam int NS  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic mr_reset, func, cond, rd;
  logic [2:0] ds, ch, sel;
  logic [NCH-1:0] halt;
  logic [2*NS-1:0] magic;
  logic [NCH-1:0] run, start;
  logic ir, dram;
  logic [NS-1:0] us;
  logic [7:0] dd;

  int checks = 0;
  int errors = 0;

  con_run_ctl #(.NCH(NCH), .SYNC_DEPTH(D), .NSTATE(NS)) dut (
    .clk(clk), .MR_RESET(mr_reset), .DIAG_CTL_FUNC_01x(func), .DIAG_DS(ds),
    .DIAG_CH(ch), .HALT(halt), .COND_EBOX_STATE(cond), .MAGIC(magic),
    .DIAG_READ(rd), .DIAG_SEL(sel), .RUN(run), .START(start), .IR_STROBE(ir),
    .DRAM_STROBE(dram), .UCODE_STATE(us), .DIAG_DATA(dd)
  );

  // Model: run latch history, pending start with its due edge, step flags.
  bit [NCH-1:0] m_runl, m_pend, m_step, m_start;
  int unsigned  m_due[NCH];
  bit [NS-1:0]  m_us;
  bit           m_ir, m_dram;
  bit [NCH-1:0] m_hist[$];
  int unsigned  cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s @%0d: got %0h expected %0h", tag, cyc, got, want);
    end
  endtask

  function automatic bit [NCH-1:0] exp_run();
    return (m_hist.size() > D) ? m_hist[D] : '0;
  endfunction

  function automatic bit [7:0] exp_diag();
    bit [15:0] v;
    v = '0;
    if (!rd) return 8'h00;
    case (sel)
      3'd0: v = 16'(exp_run());
      3'd1: v = 16'(m_pend);
      3'd2: v = 16'(m_runl);
      3'd3: v = 16'(m_us);
      3'd4: v = (16'(m_step) << NCH) | 16'(halt);
      default: v = '0;
    endcase
    return v[7:0];
  endfunction

  task automatic model_edge();
    bit hit, fired, cnt, setr, clrr, stp, dn;
    cyc++;
    if (mr_reset) begin
      m_runl = '0; m_pend = '0; m_step = '0; m_start = '0;
      m_us = '0; m_ir = 0; m_dram = 0;
      m_hist.delete();
      return;
    end
    m_ir   = func && ds == 3'b100;
    m_dram = func && ds == 3'b101;
    for (int c = 0; c < NCH; c++) begin
      hit   = func && (int'(ch) == c);
      fired = m_pend[c] && (m_due[c] == cyc);
      cnt   = hit && ds == 3'b010;
      setr  = hit && ds == 3'b001;
      clrr  = (hit && ds == 3'b000) || halt[c];
      stp   = 0;
`ifdef CON_RUN_STEP_EN
      stp   = hit && ds == 3'b011;
`endif
      m_start[c] = fired;
      if (cnt || stp) begin
        if (!m_pend[c] || fired) m_due[c] = cyc + D;
        m_pend[c] = 1;
      end else if (fired) begin
        m_pend[c] = 0;
      end
      dn = fired && m_step[c];
      if (dn)          begin m_runl[c] = 0; m_step[c] = 0; end
      if (setr || stp) m_runl[c] = 1;
      if (stp)         m_step[c] = 1;
      if (clrr)        begin m_runl[c] = 0; m_step[c] = 0; end
    end
    if (cond)
      for (int i = 0; i < NS; i++) begin
        if (magic[2*i+1])    m_us[i] = 1;
        else if (!magic[2*i]) m_us[i] = 0;
      end
    m_hist.push_front(m_runl);
    if (m_hist.size() > D + 1) void'(m_hist.pop_back());
  endtask

  task automatic idle();
    func = 0; ds = '0; ch = '0; cond = 0; magic = '0; halt = '0; rd = 0; sel = '0;
  endtask

  task automatic tick();
    #1 check("diag_data", 32'(dd), 32'(exp_diag()));
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("run", 32'(run), 32'(exp_run()));
    check("start", 32'(start), 32'(m_start));
    check("ir", 32'(ir), 32'(m_ir));
    check("dram", 32'(dram), 32'(m_dram));
    check("ucode", 32'(us), 32'(m_us));
    func = 0; cond = 0;
  endtask

  task automatic diag(input logic [2:0] f, input logic [2:0] c);
    func = 1; ds = f; ch = c;
  endtask

  initial begin
    idle();
    mr_reset = 1;
    repeat (2) @(posedge clk);
    model_edge();
    @(negedge clk);
    check("rst_run", 32'(run), 0);
    check("rst_start", 32'(start), 0);
    check("rst_strobes", 32'({ir, dram}), 0);
    check("rst_ucode", 32'(us), 0);
    check("rst_diag", 32'(dd), 0);
    mr_reset = 0;
    tick();

    // SET_RUN ch1: RUN follows D edges later, ch0 untouched
    diag(3'b001, 3'd1); tick();
    tick(); tick();
    check("set_run_early", 32'(run), 32'(2'b00));
    tick();
    check("set_run_d", 32'(run), 32'(2'b10));

    // CONTINUE coalescing and same-edge re-arm
    diag(3'b010, 3'd0); tick();
    diag(3'b010, 3'd0); tick();
    tick();
    check("cont_pre", 32'(start), 0);
    diag(3'b010, 3'd0); tick();
    check("cont_pulse", 32'(start), 32'(2'b01));
    tick();
    check("cont_single", 32'(start), 0);
    tick(); tick();
    check("cont_rearm", 32'(start), 32'(2'b01));
    tick();

    // SET_RUN with HALT in the same cycle: clear wins
    halt = 2'b01; diag(3'b001, 3'd0); tick(); halt = '0;
    for (int k = 0; k < D + 2; k++) begin
      tick();
      check("halt_run0", 32'(run[0]), 0);
    end

    // Reset mid-chain
    diag(3'b001, 3'd0); tick();
    diag(3'b010, 3'd0); tick();
    mr_reset = 1; tick(); mr_reset = 0;
    for (int k = 0; k < D + 3; k++) begin
      tick();
      check("rst_mid_run", 32'(run), 0);
      check("rst_mid_start", 32'(start), 0);
    end

    // Ucode state: set / hold / clear per pair
    cond = 1; magic = 8'b10_01_00_11; tick();
    check("us_from0", 32'(us), 32'(4'b1001));
    cond = 1; magic = 8'b10_10_10_10; tick();
    check("us_all", 32'(us), 32'(4'b1111));
    cond = 1; magic = 8'b10_01_00_11; tick();
    check("us_from_f", 32'(us), 32'(4'b1101));
    magic = '0; tick();
    check("us_hold", 32'(us), 32'(4'b1101));
    rd = 1; sel = 3'd3;
    #1 check("rb_ucode", 32'(dd), 32'h0D);
    rd = 0;
    #1 check("rb_off", 32'(dd), 0);
    tick();

    // IR strobe is a single registered pulse
    diag(3'b100, 3'd7); tick();
    check("ir_pulse", 32'(ir), 1);
    tick();
    check("ir_done", 32'(ir), 0);

`ifdef CON_RUN_STEP_EN
    diag(3'b011, 3'd0); tick();
    tick(); tick();
    check("step_pre", 32'(start), 0);
    tick();
    check("step_start", 32'(start), 32'(2'b01));
    check("step_run3", 32'(run[0]), 1);
    tick(); tick();
    check("step_run5", 32'(run[0]), 1);
    tick();
    check("step_run6", 32'(run[0]), 0);
`else
    diag(3'b011, 3'd0); tick();
    for (int k = 0; k < D + 2; k++) begin
      rd = 1; sel = 3'd1;
      tick();
      check("nostep_run", 32'(run[0]), 0);
      check("nostep_start", 32'(start), 0);
    end
`endif
    idle();
    tick();

    for (int n = 0; n < 3000; n++) begin
      mr_reset = ($urandom_range(0, 99) == 0);
      func  = ($urandom_range(0, 2) == 0);
      ds    = 3'($urandom);
      ch    = 3'($urandom_range(0, 3));
      halt  = ($urandom_range(0, 7) == 0) ? NCH'($urandom) : '0;
      cond  = ($urandom_range(0, 3) == 0);
      magic = (2*NS)'($urandom);
      rd    = 1'($urandom);
      sel   = 3'($urandom);
      tick();
    end
    mr_reset = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
